// File: rtl/smc_pkg.sv
// Shared types and constants for the serial MOSFET calculator.
// No logic: parameters, FSM state encoding and mode bit positions only.
package smc_pkg;
  localparam int N_MOS    = 6;
  localparam int VW       = 9;
  localparam int OUT_W    = 8;
  localparam int SUM_W    = 12;
  localparam int MODE_ID  = 0;
  localparam int MODE_MAX = 1;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
endpackage

// File: rtl/smc_seq_if.sv
// Descriptor beat handshake plus result strobe of smc_seq.
// master = pattern source / checker side, slave = smc_seq.
interface smc_seq_if;
  import smc_pkg::*;

  logic             in_valid;
  logic [1:0]       mode;
  logic [2:0]       W;
  logic [2:0]       V_GS;
  logic [2:0]       V_DS;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_n;

  modport master (output in_valid, mode, W, V_GS, V_DS,
                  input  in_ready, out_valid, out_n);
  modport slave  (input  in_valid, mode, W, V_GS, V_DS,
                  output in_ready, out_valid, out_n);
endinterface

// File: rtl/mos_value.sv
// Per-transistor scaled gm/Id value, purely combinational (zero latency).
// No handshake of its own; the caller decides when the result is used.
module mos_value
  import smc_pkg::*;
(
  input  logic          id_mode,
  input  logic [2:0]    w,
  input  logic [2:0]    v_gs,
  input  logic [2:0]    v_ds,
  output logic [VW-1:0] value
);
  logic [2:0] vg1;
  logic       triode;
  logic [6:0] prod_gd;
  logic [6:0] sq_d;
  logic [6:0] sq_g;
  logic [5:0] mult;

  always_comb begin
    vg1     = v_gs - 3'd1;
    triode  = vg1 > v_ds;
    prod_gd = 7'(vg1) * 7'(v_ds);
    sq_d    = 7'(v_ds) * 7'(v_ds);
    sq_g    = 7'(vg1) * 7'(vg1);
    mult    = '0;
    if (id_mode)
      mult = triode ? 6'((prod_gd << 1) - sq_d) : 6'(sq_g);
    else
      mult = triode ? {2'b00, v_ds, 1'b0} : {2'b00, vg1, 1'b0};
    value = VW'((10'(w) * 10'(mult)) / 10'd3);
  end
endmodule

// File: rtl/smc_seq.sv
// Serial MOSFET calculator: six beats are insertion-sorted, then the top/bottom three are averaged.
// Result strobes two cycles after the 6th accepted beat; in_ready drops during CALC/OUT and beats offered then are dropped.
module smc_seq
  import smc_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  smc_seq_if.slave bus
);
  state_t           state, state_nxt;
  logic [2:0]       count;
  logic [1:0]       mode_q;
  logic [VW-1:0]    sbuf     [N_MOS];
  logic [VW-1:0]    base     [N_MOS];
  logic [VW-1:0]    sbuf_nxt [N_MOS];
  logic [N_MOS-1:0] ge;
  logic [VW-1:0]    value;
  logic [VW-1:0]    a, b, c;
  logic [SUM_W-1:0] sum_nxt, sum_q, quot;
  logic             id_sel;
  logic             accept;

  assign accept = bus.in_valid && bus.in_ready;
  assign id_sel = (state == IDLE) ? bus.mode[MODE_ID] : mode_q[MODE_ID];

  mos_value u_value (
    .id_mode (id_sel),
    .w       (bus.W),
    .v_gs    (bus.V_GS),
    .v_ds    (bus.V_DS),
    .value   (value)
  );

  // A new job starts from an all-zero buffer; zero fillers behave as the smallest
  // entries, so dropping an inserted 0 off the bottom leaves the multiset correct.
  always_comb begin
    for (int i = 0; i < N_MOS; i++) begin
      base[i] = (state == IDLE) ? '0 : sbuf[i];
      ge[i]   = base[i] >= value;
    end
    sbuf_nxt[0] = ge[0] ? base[0] : value;
    for (int i = 1; i < N_MOS; i++) begin
      if (ge[i])
        sbuf_nxt[i] = base[i];
      else if (ge[i-1])
        sbuf_nxt[i] = value;
      else
        sbuf_nxt[i] = base[i-1];
    end
  end

  always_comb begin
    a = mode_q[MODE_MAX] ? sbuf[0] : sbuf[3];
    b = mode_q[MODE_MAX] ? sbuf[1] : sbuf[4];
    c = mode_q[MODE_MAX] ? sbuf[2] : sbuf[5];
    if (mode_q[MODE_ID])
      sum_nxt = 12'(a) * 12'd3 + 12'(b) * 12'd4 + 12'(c) * 12'd5;
    else
      sum_nxt = 12'(a) + 12'(b) + 12'(c);
    quot = sum_q / 12'd3;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_n     = '0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && count == 3'(N_MOS - 1)) state_nxt = CALC;
      end
      CALC: state_nxt = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        bus.out_n     = mode_q[MODE_ID] ? OUT_W'(quot >> 2) : OUT_W'(quot);
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      mode_q <= '0;
      sum_q  <= '0;
      for (int i = 0; i < N_MOS; i++) sbuf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sbuf  <= sbuf_nxt;
        count <= (state == IDLE) ? 3'd1 : count + 3'd1;
        if (state == IDLE) mode_q <= bus.mode;
      end
      if (state == CALC) sum_q <= sum_nxt;
      if (state == OUT) count <= '0;
    end
  end
endmodule

// File: tb/tb_smc_seq.sv
// Randomized scoreboard bench for smc_seq; a high-level reference model predicts each result.
// The driver pushes expected results and strobe cycles; an independent monitor pops and compares.
module tb_smc_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  smc_seq_if bus ();

  smc_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int        exp_q[$];
  int        cyc_q[$];
  int        vals[6];
  int        cnt = 0;
  int        busy_until = 0;
  logic [1:0] jmode = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mval(input bit id, input int w, input int gs, input int ds);
    int vg1;
    int m;
    vg1 = (gs + 7) % 8;
    if (id) m = (vg1 > ds) ? (2 * vg1 * ds - ds * ds) : vg1 * vg1;
    else    m = (vg1 > ds) ? 2 * ds : 2 * vg1;
    return (w * (m % 64)) / 3;
  endfunction

  function automatic int mres(input logic [1:0] md);
    int s[6];
    int t;
    int x, y, z;
    s = vals;
    for (int i = 0; i < 6; i++)
      for (int j = i + 1; j < 6; j++)
        if (s[j] > s[i]) begin t = s[i]; s[i] = s[j]; s[j] = t; end
    if (md[1]) begin x = s[0]; y = s[1]; z = s[2]; end
    else       begin x = s[3]; y = s[4]; z = s[5]; end
    if (md[0]) return (((3 * x + 4 * y + 5 * z) % 4096) / 3 / 4) % 256;
    return (((x + y + z) % 4096) / 3) % 256;
  endfunction

  // One cycle of stimulus; the model decides readiness from its own job bookkeeping.
  task automatic step(input bit v, input logic [1:0] md, input logic [2:0] w,
                      input logic [2:0] gs, input logic [2:0] ds);
    bit exp_rdy;
    @(negedge clk);
    bus.in_valid = v;
    bus.mode     = md;
    bus.W        = w;
    bus.V_GS     = gs;
    bus.V_DS     = ds;
    #1;
    exp_rdy = (cyc >= busy_until);
    check("in_ready", bus.in_ready, exp_rdy);
    if (v && exp_rdy) begin
      if (cnt == 0) jmode = md;
      vals[cnt] = mval(jmode[0], w, gs, ds);
      cnt++;
      if (cnt == 6) begin
        exp_q.push_back(mres(jmode));
        cyc_q.push_back(cyc + 2);
        busy_until = cyc + 3;
        cnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
  endtask

  task automatic rand_beat(input bit v);
    step(v, 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_n", bus.out_n, 0);
    cnt = 0;
    busy_until = 0;
    @(negedge clk);
    check("rst hold out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    int e, ec;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected out_valid: out_n=%0d at cycle %0d, no result pending", bus.out_n, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          check("out_n", bus.out_n, e);
          check("out_valid cycle", cyc, ec);
        end
      end else begin
        check("out_n while idle", bus.out_n, 0);
      end
    end
  end

  initial begin : driver
    bus.in_valid = 1'b0;
    bus.mode     = 2'b00;
    bus.W        = 3'd0;
    bus.V_GS     = 3'd0;
    bus.V_DS     = 3'd0;
    #1;
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_n", bus.out_n, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // gm, largest three then smallest three
    for (int i = 1; i <= 6; i++) step(1'b1, 2'b10, 3'(i), 3'd2, 3'd7);
    idle(3);
    for (int i = 1; i <= 6; i++) step(1'b1, 2'b00, 3'(i), 3'd2, 3'd7);
    idle(3);
    // Id, all equal triode values
    for (int i = 0; i < 6; i++) step(1'b1, 2'b01, 3'd7, 3'd7, 3'd1);
    idle(3);
    // Id, largest three, saturation, two-cycle gaps
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b11, 3'd3, 3'd3, 3'd3);
      idle(2);
    end
    idle(2);
    // Busy junk held through CALC/OUT, then a back-to-back second job
    for (int i = 0; i < 6; i++) rand_beat(1'b1);
    for (int i = 0; i < 8; i++) rand_beat(1'b1);
    idle(3);
    // Reset after three accepted beats, then a fresh job
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 3'd7, 3'd0, 3'd0);
    pulse_reset();
    for (int i = 0; i < 6; i++) rand_beat(1'b1);
    idle(3);
    // Random traffic with gaps and mid-job mode changes
    for (int i = 0; i < 400; i++) rand_beat($urandom_range(0, 3) != 0);
    idle(4);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("results outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
